ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch.sv | 177 +++++++++++++++++
 tb/tb_ifetch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch: issues word-aligned fetches and buffers returned words for the decoder.
// Latency: response accepted in cycle N appears on inst/inst_pc in cycle N+1 (registered head).
// Backpressure: requests issue only while outstanding + buffered < 2, so a stalled decoder stops fetch.

// Two-entry in-order queue with flush; the head is read straight from the storage registers.
module ifetch_fifo #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic [1:0]   cnt_o
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;

  // Next-state: flush empties the queue and overrides any same-cycle push or pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_dat_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  // Storage and pointer registers; reset clears contents so the head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign cnt_o      = cnt_q;

endmodule

module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  drp_q, drp_d;

  // Outstanding count is the occupancy of the address queue: one entry per
  // issued request whose response has not yet come back.
  logic [1:0]  osd;
  logic [31:0] aq_head;
  logic [1:0]  ibuf_cnt;
  logic [63:0] ibuf_head;
  logic [2:0]  credit_used;

  logic        req_hs;
  logic        rsp_live;
  logic        ibuf_push;
  logic        ibuf_pop;

  assign credit_used = {1'b0, osd} + {1'b0, ibuf_cnt};

  // rst_n gates the request so it reads low throughout reset and high in the
  // very first cycle after release.
  assign imem_req_valid = rst_n && !redirect_valid && (credit_used < 3'd2);
  assign imem_req_addr  = fetch_pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rsp_live  = imem_rsp_valid && (osd != 2'd0);
  assign ibuf_push = rsp_live && (drp_q == 2'd0) && !redirect_valid;
  assign ibuf_pop  = inst_valid && inst_ready && !redirect_valid;

  // Addresses of in-flight requests, oldest at the head; popped by every live
  // response, whether kept or dropped, so it never needs flushing.
  ifetch_fifo #(.W(32)) u_addr_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (1'b0),
    .push_i     (req_hs),
    .push_dat_i (fetch_pc_q),
    .pop_i      (rsp_live),
    .head_dat_o (aq_head),
    .cnt_o      (osd)
  );

  // Instruction buffer of {pc, word}; a redirect discards it, including any
  // push or pop requested in the same cycle.
  ifetch_fifo #(.W(64)) u_inst_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (redirect_valid),
    .push_i     (ibuf_push),
    .push_dat_i ({aq_head, imem_rsp_data}),
    .pop_i      (ibuf_pop),
    .head_dat_o (ibuf_head),
    .cnt_o      (ibuf_cnt)
  );

  assign inst_valid = (ibuf_cnt != 2'd0);
  assign inst_pc    = ibuf_head[63:32];
  assign inst       = ibuf_head[31:0];

  // Next fetch address and drop count: a redirect reloads the pc and marks
  // every request still outstanding after this cycle as stale.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drp_d      = drp_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      drp_d      = osd - {1'b0, rsp_live};
    end else begin
      if (req_hs) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_live && (drp_q != 2'd0)) begin
        drp_d = drp_q - 2'd1;
      end
    end
  end

  // Fetch pc and drop count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC_ALIGNED;
      drp_q      <= 2'd0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drp_q      <= drp_d;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: reset, streaming, stall, redirects, wrap, async reset.
// Latency: checks the 1-cycle memory / next-cycle decoder timing directly.
// Backpressure: exercises decoder stall and the two-credit request limit.
module tb_ifetch;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  logic        mem_auto = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] req_log[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];

  ifetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: log handshakes and pops seen this cycle, then move to the next
  // falling edge; the auto memory answers each handshake one cycle later.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    #1;
    hs = imem_req_valid && imem_req_ready;
    a  = imem_req_addr;
    if (hs) req_log.push_back(a);
    if (inst_valid && inst_ready && !redirect_valid) begin
      got_pc.push_back(inst_pc);
      got_inst.push_back(inst);
    end
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    if (mem_auto) begin
      imem_rsp_valid = hs;
      imem_rsp_data  = a ^ K;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    req_log.delete();
    got_pc.delete();
    got_inst.delete();
    #1;
  endtask

  initial begin
    // Reset values
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("rst_req_vld", {31'b0, imem_req_valid}, 32'd0);
    check("rst_inst_vld", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_req_addr", imem_req_addr, 32'h0);

    // Streaming with an always-ready 1-cycle memory
    do_reset();
    mem_auto = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    check("rel_req_vld", {31'b0, imem_req_valid}, 32'd1);
    check("rel_req_addr", imem_req_addr, 32'h0);
    tick();
    check("c1_inst_vld", {31'b0, inst_valid}, 32'd0);
    check("c1_req_addr", imem_req_addr, 32'h4);
    tick();
    check("lat_inst_vld", {31'b0, inst_valid}, 32'd1);
    check("lat_inst_pc", inst_pc, 32'h0);
    check("lat_inst", inst, K);
    for (int i = 0; i < 40 && got_pc.size() < 4; i++) tick();
    check("stream_cnt", got_pc.size(), 32'd4);
    for (int i = 0; i < 4 && i < got_pc.size(); i++) begin
      check($sformatf("stream_pc%0d", i), got_pc[i], 32'(4 * i));
      check($sformatf("stream_inst%0d", i), got_inst[i], 32'(4 * i) ^ K);
    end

    // Decoder stall: two credits, then resume in order
    do_reset();
    mem_auto = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b0;
    repeat (10) tick();
    check("stall_reqs", req_log.size(), 32'd2);
    check("stall_inst_vld", {31'b0, inst_valid}, 32'd1);
    check("stall_inst_pc", inst_pc, 32'h0);
    check("stall_req_vld", {31'b0, imem_req_valid}, 32'd0);
    inst_ready = 1'b1;
    for (int i = 0; i < 60 && got_pc.size() < 6; i++) tick();
    check("resume_cnt", got_pc.size(), 32'd6);
    for (int i = 0; i < 6 && i < got_pc.size(); i++) begin
      check($sformatf("resume_pc%0d", i), got_pc[i], 32'(4 * i));
      check($sformatf("resume_inst%0d", i), got_inst[i], 32'(4 * i) ^ K);
    end

    // Redirect with two outstanding: late responses dropped
    do_reset();
    mem_auto = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
    tick();
    tick();
    check("osd2_req_vld", {31'b0, imem_req_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    check("redir_req_vld", {31'b0, imem_req_valid}, 32'd0);
    tick();
    check("drp_wait_vld", {31'b0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0000;
    tick();
    check("drop1_inst_vld", {31'b0, inst_valid}, 32'd0);
    check("redir_req_vld1", {31'b0, imem_req_valid}, 32'd1);
    check("redir_req_addr", imem_req_addr, 32'h0000_0100);
    imem_rsp_data = 32'hBAD0_0004;
    tick();
    check("drop2_inst_vld", {31'b0, inst_valid}, 32'd0);
    imem_rsp_data = 32'h1234_0100;
    tick();
    imem_rsp_valid = 1'b0;
    check("redir_inst_vld", {31'b0, inst_valid}, 32'd1);
    check("redir_inst_pc", inst_pc, 32'h0000_0100);
    check("redir_inst", inst, 32'h1234_0100);

    // Redirect coinciding with a response and a pop
    do_reset();
    mem_auto = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_0000;
    tick();
    check("pre_inst_vld", {31'b0, inst_valid}, 32'd1);
    imem_rsp_data = 32'h2222_0004;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    imem_rsp_valid = 1'b0;
    check("flush_inst_vld", {31'b0, inst_valid}, 32'd0);
    check("flush_req_vld", {31'b0, imem_req_valid}, 32'd1);
    check("flush_req_addr", imem_req_addr, 32'h0000_0200);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h3333_0200;
    tick();
    imem_rsp_valid = 1'b0;
    check("nodrop_inst_vld", {31'b0, inst_valid}, 32'd1);
    check("nodrop_inst_pc", inst_pc, 32'h0000_0200);
    check("nodrop_inst", inst, 32'h3333_0200);

    // Back-to-back redirects, then address wrap
    do_reset();
    mem_auto = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFB;
    tick();
    check("b2b_req_addr", imem_req_addr, 32'hFFFF_FFF8);
    for (int i = 0; i < 20 && got_pc.size() < 3; i++) tick();
    check("wrap_reqs_ge3", {31'b0, req_log.size() >= 3}, 32'd1);
    if (req_log.size() >= 3) begin
      check("wrap_addr0", req_log[0], 32'hFFFF_FFF8);
      check("wrap_addr1", req_log[1], 32'hFFFF_FFFC);
      check("wrap_addr2", req_log[2], 32'h0000_0000);
    end
    check("wrap_pops", got_pc.size(), 32'd3);
    if (got_pc.size() >= 3) begin
      check("wrap_inst0", got_inst[0], 32'h5A5A_FFF8);
      check("wrap_pc2", got_pc[2], 32'h0000_0000);
    end

    // Unsolicited response, then async reset mid-stream
    do_reset();
    mem_auto = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    check("unsol_inst_vld", {31'b0, inst_valid}, 32'd0);
    check("unsol_req_vld", {31'b0, imem_req_valid}, 32'd1);
    check("unsol_req_addr", imem_req_addr, 32'h0);
    mem_auto = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b0;
    repeat (4) tick();
    check("mid_inst_vld", {31'b0, inst_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req_vld", {31'b0, imem_req_valid}, 32'd0);
    check("arst_inst_vld", {31'b0, inst_valid}, 32'd0);
    check("arst_inst", inst, 32'h0);
    check("arst_inst_pc", inst_pc, 32'h0);
    check("arst_req_addr", imem_req_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; imem_rsp_valid = 1'b0; inst_ready = 1'b1;
    req_log.delete(); got_pc.delete(); got_inst.delete();
    #1;
    check("rerun_req_vld", {31'b0, imem_req_valid}, 32'd1);
    check("rerun_req_addr", imem_req_addr, 32'h0);
    for (int i = 0; i < 10 && got_pc.size() < 1; i++) tick();
    check("rerun_pops", got_pc.size(), 32'd1);
    if (got_pc.size() >= 1) begin
      check("rerun_pc", got_pc[0], 32'h0);
      check("rerun_inst", got_inst[0], K);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
